reg_bank_arbiter: RTL and testbench

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

---
 rtl/reg_bank_arbiter.sv | 146 ++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin arbiter in front of a single register bank (IDLE/ACCESS/RESP).
// Define ARB_TIMEOUT_EN to abort an ACCESS with err=1 after TIMEOUT_CYC cycles without bank_ack.
module reg_bank_arbiter #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned REG_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              m0_req,
  input  logic              m0_wr_rdn,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [REG_W-1:0]  m0_wdata,
  output logic              m0_done,
  output logic [REG_W-1:0]  m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_wr_rdn,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [REG_W-1:0]  m1_wdata,
  output logic              m1_done,
  output logic [REG_W-1:0]  m1_rdata,
  output logic              m1_err,
  output logic              bank_wr_rdn,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [REG_W-1:0]  bank_wdata,
  output logic              bank_we,
  input  logic [REG_W-1:0]  bank_rdata,
  input  logic              bank_ack,
  input  logic              bank_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  state_e            state_q;
  logic              gnt_q;
  logic              prio_q;
  logic [1:0]        done_q;
  logic [1:0]        err_q;
  logic [REG_W-1:0]  rdata_q [2];
  logic              bank_we_q;
  logic              bank_wr_rdn_q;
  logic [ADDR_W-1:0] bank_addr_q;
  logic [REG_W-1:0]  bank_wdata_q;

  logic              win_d;
  logic              grant_d;
  logic              sel_wr_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [REG_W-1:0]  sel_wdata_d;
  logic              tmo_hit;

  // prio_q names the requester that wins a tie; it always points away from the last grant.
  assign win_d       = (m0_req & m1_req) ? prio_q : m1_req;
  assign grant_d     = (state_q == IDLE) & ena & (m0_req | m1_req);
  assign sel_wr_d    = win_d ? m1_wr_rdn : m0_wr_rdn;
  assign sel_addr_d  = win_d ? m1_addr   : m0_addr;
  assign sel_wdata_d = win_d ? m1_wdata  : m0_wdata;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] tmo_q;

  // tmo_q counts ack-less ACCESS cycles already elapsed; this cycle would be number TIMEOUT_CYC.
  assign tmo_hit = ~bank_ack & (tmo_q == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (grant_d) begin
      tmo_q <= '0;
    end else if (state_q == ACCESS && !bank_ack) begin
      tmo_q <= tmo_q + 8'd1;
    end
  end
`else
  // TIMEOUT_CYC is never 0, so this is a constant low with no counter behind it.
  assign tmo_hit = (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_q         <= 1'b0;
      prio_q        <= 1'b0;
      done_q        <= 2'b00;
      err_q         <= 2'b00;
      rdata_q[0]    <= '0;
      rdata_q[1]    <= '0;
      bank_we_q     <= 1'b0;
      bank_wr_rdn_q <= 1'b0;
      bank_addr_q   <= '0;
      bank_wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            gnt_q         <= win_d;
            prio_q        <= ~win_d;
            bank_wr_rdn_q <= sel_wr_d;
            bank_addr_q   <= sel_addr_d;
            bank_wdata_q  <= sel_wdata_d;
            bank_we_q     <= sel_wr_d;
            state_q       <= ACCESS;
          end
        end
        ACCESS: begin
          bank_we_q <= 1'b0;
          if (bank_ack) begin
            if (!bank_wr_rdn_q) begin
              rdata_q[gnt_q] <= bank_rdata;
            end
            err_q[gnt_q]  <= bank_err;
            done_q[gnt_q] <= 1'b1;
            state_q       <= RESP;
          end else if (tmo_hit) begin
            err_q[gnt_q]  <= 1'b1;
            done_q[gnt_q] <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: begin
          done_q  <= 2'b00;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m0_done     = done_q[0];
  assign m1_done     = done_q[1];
  assign m0_err      = err_q[0];
  assign m1_err      = err_q[1];
  assign m0_rdata    = rdata_q[0];
  assign m1_rdata    = rdata_q[1];
  assign bank_we     = bank_we_q;
  assign bank_wr_rdn = bank_wr_rdn_q;
  assign bank_addr   = bank_addr_q;
  assign bank_wdata  = bank_wdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: transaction-level model predicts grant order and
// responses; a monitor pops expectations on every done pulse.
module tb_reg_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       m0_req = 1'b0, m0_wr_rdn = 1'b0;
  logic [7:0] m0_addr = 8'h00, m0_wdata = 8'h00;
  logic       m1_req = 1'b0, m1_wr_rdn = 1'b0;
  logic [7:0] m1_addr = 8'h00, m1_wdata = 8'h00;
  logic       m0_done, m0_err, m1_done, m1_err;
  logic [7:0] m0_rdata, m1_rdata;
  logic       bank_wr_rdn, bank_we, bank_ack = 1'b1, bank_err, busy;
  logic [7:0] bank_addr, bank_wdata, bank_rdata;

  always #5 clk = ~clk;

  reg_bank_arbiter #(.ADDR_W(8), .REG_W(8), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .m0_req(m0_req), .m0_wr_rdn(m0_wr_rdn), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_wr_rdn(m1_wr_rdn), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .bank_wr_rdn(bank_wr_rdn), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_we(bank_we), .bank_rdata(bank_rdata), .bank_ack(bank_ack),
    .bank_err(bank_err), .busy(busy)
  );

  // Register bank: addresses 0xF0 and up report an error.
  logic [7:0] mem [256] = '{default: 8'h00};
  assign bank_rdata = mem[bank_addr];
  assign bank_err   = (bank_addr >= 8'hF0);
  always @(posedge clk) if (bank_we) mem[bank_addr] <= bank_wdata;

  // Ack source: tied high, held low, or random with at most two misses in a row.
  bit ack_tie = 1'b1, ack_hold0 = 1'b0;
  int miss = 0;
  always begin
    @(posedge clk);
    #2;
    if (ack_hold0)    bank_ack = 1'b0;
    else if (ack_tie) bank_ack = 1'b1;
    else              bank_ack = (miss >= 2) || ($urandom_range(0, 2) == 0);
    miss = (busy && !bank_ack) ? miss + 1 : 0;
  end

  int checks = 0, errors = 0;
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endfunction

  // Reference model: transaction level memory, per-requester status and tie priority.
  typedef struct { bit who; bit wr; logic [7:0] rdata; bit err; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  logic [7:0] mdl_rdata [2] = '{8'h00, 8'h00};
  bit         prio_m = 1'b0;

  task automatic model_txn(input bit w, input bit wr, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.who = w;
    e.wr  = wr;
    e.err = (a >= 8'hF0);
    if (wr) begin
      ref_mem[a] = d;
      e.rdata = mdl_rdata[w];
    end else begin
      e.rdata = ref_mem[a];
      mdl_rdata[w] = e.rdata;
    end
    prio_m = ~w;
    exp_q.push_back(e);
  endtask

  // Monitor: one transaction line per completion; idle requester's status must hold.
  logic [7:0] held_rd [2] = '{8'h00, 8'h00};
  bit         held_err [2] = '{1'b0, 1'b0};
  int         we_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    bit   w;
    if (rst) begin
      held_rd[0] = 8'h00; held_rd[1] = 8'h00;
      held_err[0] = 1'b0; held_err[1] = 1'b0;
      we_cnt = 0;
    end else begin
      if (bank_we) we_cnt++;
      if (m0_done || m1_done) begin
        check("single_done", 32'(m0_done & m1_done), 32'd0);
        w = m1_done;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("txn m%0d %s rdata=%02h err=%0b", w, e.wr ? "wr" : "rd",
                   w ? m1_rdata : m0_rdata, w ? m1_err : m0_err);
          check("grant_who", 32'(w), 32'(e.who));
          check("rdata", 32'(w ? m1_rdata : m0_rdata), 32'(e.rdata));
          check("err", 32'(w ? m1_err : m0_err), 32'(e.err));
          check("we_cycles", 32'(we_cnt), 32'(e.wr));
          held_rd[w]  = e.rdata;
          held_err[w] = e.err;
        end
        we_cnt = 0;
      end
      if (!m0_done) check("m0_status_hold", {23'd0, m0_err, m0_rdata}, {23'd0, held_err[0], held_rd[0]});
      if (!m1_done) check("m1_status_hold", {23'd0, m1_err, m1_rdata}, {23'd0, held_err[1], held_rd[1]});
    end
  end

  task automatic set_m(input bit w, input bit wr, input logic [7:0] a, input logic [7:0] d);
    if (!w) begin m0_wr_rdn = wr; m0_addr = a; m0_wdata = d; end
    else    begin m1_wr_rdn = wr; m1_addr = a; m1_wdata = d; end
  endtask

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 8'hF0 | 8'($urandom_range(0, 3));
    return 8'($urandom_range(0, 15));
  endfunction

  // Each requester repeats its current op n times, holding req until its last done.
  task automatic run_seq(input int n0, input int n1, input bit rnd_ena, input bit chk_busy);
    int r0 = n0, r1 = n1, p0 = n0, p1 = n1, idle_ph = 0;
    bit w;
    while (p0 > 0 || p1 > 0) begin
      w = (p0 > 0 && p1 > 0) ? prio_m : (p1 > 0);
      if (!w) begin model_txn(1'b0, m0_wr_rdn, m0_addr, m0_wdata); p0--; end
      else    begin model_txn(1'b1, m1_wr_rdn, m1_addr, m1_wdata); p1--; end
    end
    m0_req = (r0 > 0);
    m1_req = (r1 > 0);
    for (int cyc = 0; cyc < 400 && (r0 > 0 || r1 > 0); cyc++) begin
      @(negedge clk);
      if (chk_busy && idle_ph == 1)      check("busy_idle_gap", 32'(busy), 32'd0);
      else if (chk_busy && idle_ph == 2) check("busy_after_gap", 32'(busy), 32'd1);
      idle_ph = (idle_ph == 1) ? 2 : 0;
      if (m0_done) begin r0--; if (r0 <= 0) m0_req = 1'b0; end
      if (m1_done) begin r1--; if (r1 <= 0) m1_req = 1'b0; end
      if ((m0_done || m1_done) && (r0 > 0 || r1 > 0)) idle_ph = 1;
      if (rnd_ena) ena = ($urandom_range(0, 3) != 0);
    end
    check("seq_complete", 32'((r0 > 0 ? r0 : 0) + (r1 > 0 ? r1 : 0)), 32'd0);
    m0_req = 1'b0;
    m1_req = 1'b0;
    ena = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", {30'd0, m1_done, m0_done}, 32'd0);
    check("rst_rdata", {16'd0, m1_rdata, m0_rdata}, 32'd0);
    check("rst_err", {30'd0, m1_err, m0_err}, 32'd0);
    check("rst_bank_ctl", {30'd0, bank_we, bank_wr_rdn}, 32'd0);
    check("rst_bank_data", {16'd0, bank_addr, bank_wdata}, 32'd0);
    rst = 1'b0;
    ena = 1'b1;

    // Both requesters held through three transactions each: strict alternation from m0.
    set_m(1'b0, 1'b1, 8'h10, 8'h3C);
    set_m(1'b1, 1'b0, 8'h10, 8'h00);
    run_seq(3, 3, 1'b0, 1'b1);
    @(negedge clk);

    // Write then read with exact latency.
    set_m(1'b0, 1'b1, 8'h03, 8'hA5);
    model_txn(1'b0, 1'b1, 8'h03, 8'hA5);
    m0_req = 1'b1;
    @(negedge clk);
    check("wr_c1_we", 32'(bank_we), 32'd1);
    check("wr_c1_busy", 32'(busy), 32'd1);
    check("wr_c1_done", 32'(m0_done), 32'd0);
    @(negedge clk);
    check("wr_c2_done", 32'(m0_done), 32'd1);
    check("wr_c2_we", 32'(bank_we), 32'd0);
    m0_req = 1'b0;
    @(negedge clk);
    check("wr_c3_idle", 32'(busy), 32'd0);
    check("idle_addr_hold", 32'(bank_addr), 32'h03);
    set_m(1'b0, 1'b0, 8'h03, 8'h00);
    model_txn(1'b0, 1'b0, 8'h03, 8'h00);
    m0_req = 1'b1;
    @(negedge clk);
    check("rd_c1_we", 32'(bank_we), 32'd0);
    @(negedge clk);
    check("rd_c2_done", 32'(m0_done), 32'd1);
    check("rd_value", 32'(m0_rdata), 32'hA5);
    m0_req = 1'b0;
    @(negedge clk);

    // ena low blocks the grant; m1 completes two cycles after the first enabled IDLE cycle.
    ena = 1'b0;
    set_m(1'b1, 1'b0, 8'h03, 8'h00);
    model_txn(1'b1, 1'b0, 8'h03, 8'h00);
    m1_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("ena0_busy", 32'(busy), 32'd0);
    end
    ena = 1'b1;
    @(negedge clk);
    check("ena1_c1_done", 32'(m1_done), 32'd0);
    @(negedge clk);
    check("ena1_c2_done", 32'(m1_done), 32'd1);
    m1_req = 1'b0;
    @(negedge clk);

    // Reset during the first ACCESS cycle of an m0 write.
    ack_tie = 1'b0;
    ack_hold0 = 1'b1;
    @(negedge clk);
    set_m(1'b0, 1'b1, 8'h77, 8'h5A);
    m0_req = 1'b1;
    @(negedge clk);
    check("pre_rst_we", 32'(bank_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_we", 32'(bank_we), 32'd0);
    check("mid_rst_done", 32'(m0_done), 32'd0);
    check("mid_rst_addr", 32'(bank_addr), 32'd0);
    m0_req = 1'b0;
    prio_m = 1'b0;
    mdl_rdata[0] = 8'h00;
    mdl_rdata[1] = 8'h00;
    ack_hold0 = 1'b0;
    ack_tie = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_done", {30'd0, m1_done, m0_done}, 32'd0);
    set_m(1'b1, 1'b0, 8'h03, 8'h00);
    run_seq(0, 1, 1'b0, 1'b0);
    set_m(1'b0, 1'b0, 8'h10, 8'h00);
    run_seq(1, 1, 1'b0, 1'b0);
    @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    begin
      exp_t e;
      ack_hold0 = 1'b1;
      @(negedge clk);
      set_m(1'b1, 1'b0, 8'h10, 8'h00);
      e.who = 1'b1; e.wr = 1'b0; e.rdata = mdl_rdata[1]; e.err = 1'b1;
      prio_m = 1'b0;
      exp_q.push_back(e);
      m1_req = 1'b1;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        check(k < 5 ? "tmo_no_done" : "tmo_done", 32'(m1_done), 32'(k == 5));
      end
      m1_req = 1'b0;
      ack_hold0 = 1'b0;
      @(negedge clk);
    end
`endif

    // Randomized mix of single and contending requests with random ack delay and ena.
    ack_tie = 1'b0;
    for (int t = 0; t < 40; t++) begin
      int n0, n1;
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 == 0 && n1 == 0) n0 = 1;
      set_m(1'b0, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
      set_m(1'b1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
      run_seq(n0, n1, 1'b1, 1'b0);
    end
    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
